// File: rtl/ysyx_22040632_divider.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their W forms.
// Optional macro YSYX_22040632_DIV_FASTPATH_EN: zero divisor / signed overflow bypass the iterations.
module ysyx_22040632_divider #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            div_valid,
    output logic            div_ready,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            div_signed,
    input  logic            divw,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int HALF = XLEN / 2;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    typedef struct packed {
        logic [XLEN-1:0] quo;
        logic [XLEN-1:0] rem;
    } result_t;

    // Applies sign correction, special-case overrides and word sign-extension to raw magnitudes.
    function automatic result_t fix_result(
        input logic            word,
        input logic            zero,
        input logic            ovf,
        input logic            q_neg,
        input logic            r_neg,
        input logic [XLEN-1:0] raw_dvd,
        input logic [XLEN-1:0] q_mag,
        input logic [XLEN-1:0] r_mag
    );
        logic [XLEN-1:0] quo;
        logic [XLEN-1:0] rem;
        result_t         res;
        quo = q_neg ? -q_mag : q_mag;
        rem = r_neg ? -r_mag : r_mag;
        if (zero) begin
            quo = '1;
            rem = raw_dvd;
        end else if (ovf) begin
            quo = raw_dvd;
            rem = '0;
        end
        if (word) begin
            quo = {{(XLEN-HALF){quo[HALF-1]}}, quo[HALF-1:0]};
            rem = {{(XLEN-HALF){rem[HALF-1]}}, rem[HALF-1:0]};
        end
        res.quo = quo;
        res.rem = rem;
        return res;
    endfunction

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   acc_q, acc_d;      // dividend bits shift out the top, quotient bits in the bottom
    logic [XLEN-1:0]   dsr_q, dsr_d;
    logic [XLEN-1:0]   raw_dvd_q, raw_dvd_d;
    logic              word_q, word_d;
    logic              q_neg_q, q_neg_d;
    logic              r_neg_q, r_neg_d;
    logic              zero_q, zero_d;
    logic              ovf_q, ovf_d;
    logic [XLEN-1:0]   quotient_q, quotient_d;
    logic [XLEN-1:0]   remainder_q, remainder_d;

    logic [XLEN-1:0]   dvd_ext, dsr_ext, dvd_abs, dsr_abs;
    logic              dvd_sign, dsr_sign, in_zero, in_ovf;
    logic [XLEN:0]     partial;
    logic              ge;
    logic [XLEN-1:0]   step_rem, step_acc;
    result_t           res;

    // Operand preparation on the request inputs.
    always_comb begin
        if (divw) begin
            dvd_ext = div_signed ? {{(XLEN-HALF){dividend[HALF-1]}}, dividend[HALF-1:0]}
                                 : {{(XLEN-HALF){1'b0}}, dividend[HALF-1:0]};
            dsr_ext = div_signed ? {{(XLEN-HALF){divisor[HALF-1]}}, divisor[HALF-1:0]}
                                 : {{(XLEN-HALF){1'b0}}, divisor[HALF-1:0]};
            in_ovf  = div_signed && (dividend[HALF-1:0] == {1'b1, {(HALF-1){1'b0}}})
                                 && (divisor[HALF-1:0] == {HALF{1'b1}});
        end else begin
            dvd_ext = dividend;
            dsr_ext = divisor;
            in_ovf  = div_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}})
                                 && (divisor == {XLEN{1'b1}});
        end
        dvd_sign = div_signed & dvd_ext[XLEN-1];
        dsr_sign = div_signed & dsr_ext[XLEN-1];
        dvd_abs  = dvd_sign ? -dvd_ext : dvd_ext;
        dsr_abs  = dsr_sign ? -dsr_ext : dsr_ext;
        in_zero  = (dsr_ext == '0);
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        acc_d       = acc_q;
        dsr_d       = dsr_q;
        raw_dvd_d   = raw_dvd_q;
        word_d      = word_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        res         = '0;

        partial  = {rem_q, acc_q[XLEN-1]};
        ge       = (partial >= {1'b0, dsr_q});
        step_rem = ge ? (partial[XLEN-1:0] - dsr_q) : partial[XLEN-1:0];
        step_acc = {acc_q[XLEN-2:0], ge};

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (div_valid) begin
                        state_d   = S_CALC;
                        cnt_d     = divw ? CNT_W'(HALF) : CNT_W'(XLEN);
                        rem_d     = '0;
                        acc_d     = divw ? {dvd_abs[HALF-1:0], {(XLEN-HALF){1'b0}}} : dvd_abs;
                        dsr_d     = dsr_abs;
                        raw_dvd_d = dividend;
                        word_d    = divw;
                        q_neg_d   = dvd_sign ^ dsr_sign;
                        r_neg_d   = dvd_sign;
                        zero_d    = in_zero;
                        ovf_d     = in_ovf;
`ifdef YSYX_22040632_DIV_FASTPATH_EN
                        if (in_zero || in_ovf) begin
                            state_d     = S_DONE;
                            res         = fix_result(divw, in_zero, in_ovf, 1'b0, 1'b0,
                                                     dividend, '0, '0);
                            quotient_d  = res.quo;
                            remainder_d = res.rem;
                        end
`endif
                    end
                end
                S_CALC: begin
                    rem_d = step_rem;
                    acc_d = step_acc;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d     = S_DONE;
                        res         = fix_result(word_q, zero_q, ovf_q, q_neg_q, r_neg_q, raw_dvd_q,
                                                 word_q ? {{(XLEN-HALF){1'b0}}, step_acc[HALF-1:0]}
                                                        : step_acc,
                                                 step_rem);
                        quotient_d  = res.quo;
                        remainder_d = res.rem;
                    end
                end
                S_DONE: begin
                    if (out_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            acc_q       <= '0;
            dsr_q       <= '0;
            raw_dvd_q   <= '0;
            word_q      <= 1'b0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            acc_q       <= acc_d;
            dsr_q       <= dsr_d;
            raw_dvd_q   <= raw_dvd_d;
            word_q      <= word_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign div_ready = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_ysyx_22040632_divider.sv
// Self-checking bench for ysyx_22040632_divider: directed steps with an expected-result queue.
// Honours YSYX_22040632_DIV_FASTPATH_EN for special-case latency expectations.
module tb_ysyx_22040632_divider;
    localparam int LAT64 = 65;
    localparam int LAT32 = 33;
`ifdef YSYX_22040632_DIV_FASTPATH_EN
    localparam int LAT_SP64 = 1;
    localparam int LAT_SP32 = 1;
`else
    localparam int LAT_SP64 = 65;
    localparam int LAT_SP32 = 33;
`endif

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        div_valid;
    logic        div_ready;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        div_signed;
    logic        divw;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] quotient;
    logic [63:0] remainder;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    ysyx_22040632_divider dut (
        .clk        (clk),
        .rst        (rst),
        .div_valid  (div_valid),
        .div_ready  (div_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .div_signed (div_signed),
        .divw       (divw),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, wait for its result, check latency and values, hold, then consume.
    task automatic run_op(input string name, input logic [63:0] dvd, input logic [63:0] dsr,
                          input logic sgn, input logic w, input logic [63:0] eq,
                          input logic [63:0] er, input int elat, input int hold);
        exp_t e;
        int   lat;
        dividend   = dvd;
        divisor    = dsr;
        div_signed = sgn;
        divw       = w;
        div_valid  = 1'b1;
        check({name, ".ready"}, 64'(div_ready), 64'd1);
        tick();
        div_valid = 1'b0;
        sb.push_back('{q: eq, r: er});
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        check({name, ".lat"}, 64'(lat), 64'(elat));
        if (sb.size() == 0) begin
            check({name, ".sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check({name, ".q"}, quotient, e.q);
            check({name, ".r"}, remainder, e.r);
            for (int i = 0; i < hold; i++) begin
                tick();
                check({name, ".hold_valid"}, 64'(out_valid), 64'd1);
                check({name, ".hold_q"}, quotient, e.q);
                check({name, ".hold_r"}, remainder, e.r);
                check({name, ".hold_ready"}, 64'(div_ready), 64'd0);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, ".valid_drop"}, 64'(out_valid), 64'd0);
        check({name, ".ready_back"}, 64'(div_ready), 64'd1);
    endtask

    initial begin
        int seen;
        rst        = 1'b1;
        div_valid  = 1'b0;
        dividend   = '0;
        divisor    = '0;
        div_signed = 1'b0;
        divw       = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        tick();
        tick();
        check("reset.ready", 64'(div_ready), 64'd1);
        check("reset.valid", 64'(out_valid), 64'd0);
        check("reset.q", quotient, 64'd0);
        check("reset.r", remainder, 64'd0);
        rst = 1'b0;
        tick();

        run_op("div_100_7", 64'd100, 64'd7, 1'b1, 1'b0, 64'd14, 64'd2, LAT64, 0);
        run_op("div_m7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, LAT64, 0);
        run_op("div_7_m2", 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFD, 64'd1, LAT64, 0);
        run_op("divu_max_2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b0,
               64'h7FFF_FFFF_FFFF_FFFF, 64'd1, LAT64, 0);
        run_op("divu_big", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0001_0000_0000, 1'b0, 1'b0,
               64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, LAT64, 0);
        run_op("div_by_zero", 64'd5, 64'd0, 1'b1, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFF, 64'd5, LAT_SP64, 0);
        run_op("div_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
               64'h8000_0000_0000_0000, 64'd0, LAT_SP64, 0);
        run_op("divw_ovf", 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1,
               64'hFFFF_FFFF_8000_0000, 64'd0, LAT_SP32, 0);
        run_op("divuw_1", 64'h1234_5678_FFFF_FFFF, 64'd1, 1'b0, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFF, 64'd0, LAT32, 0);
        run_op("divw_m7_2", 64'hDEAD_BEEF_FFFF_FFF9, 64'hCAFE_0000_0000_0002, 1'b1, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, LAT32, 0);
        run_op("divuw_zero", 64'h0000_0000_8000_0005, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0005, LAT_SP32, 0);

        // Result held while the consumer stalls.
        run_op("hold_100_7", 64'd100, 64'd7, 1'b1, 1'b0, 64'd14, 64'd2, LAT64, 3);

        // Flush ten cycles into CALC discards the result.
        dividend   = 64'd100;
        divisor    = 64'd3;
        div_signed = 1'b1;
        divw       = 1'b0;
        div_valid  = 1'b1;
        tick();
        div_valid = 1'b0;
        check("flush.busy", 64'(div_ready), 64'd0);
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush.valid", 64'(out_valid), 64'd0);
        check("flush.ready", 64'(div_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        check("flush.no_result", 64'(seen), 64'd0);

        // Flush wins over a simultaneous request.
        dividend  = 64'd9;
        divisor   = 64'd4;
        div_valid = 1'b1;
        flush     = 1'b1;
        tick();
        div_valid = 1'b0;
        flush     = 1'b0;
        check("flush_prio.ready", 64'(div_ready), 64'd1);

        run_op("after_flush", 64'd100, 64'd7, 1'b1, 1'b0, 64'd14, 64'd2, LAT64, 0);

        // Asynchronous reset in the middle of CALC clears outputs without a clock edge.
        dividend   = 64'd1000;
        divisor    = 64'd3;
        div_signed = 1'b0;
        divw       = 1'b0;
        div_valid  = 1'b1;
        tick();
        div_valid = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        #1;
        check("rst_mid.q", quotient, 64'd0);
        check("rst_mid.r", remainder, 64'd0);
        check("rst_mid.ready", 64'(div_ready), 64'd1);
        check("rst_mid.valid", 64'(out_valid), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        run_op("after_reset", 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFD, 64'd1, LAT64, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22040632_divider.md
Name: ysyx_22040632_divider

Overview:
- Iterative 64-bit integer divider for the NPC execute-stage ALU extension; it is the division counterpart to the Booth-based multiplier.
- Implements RV64M DIV/DIVU/REM/REMU/DIVW/DIVUW/REMW/REMUW semantics with a radix-2 restoring shift-subtract datapath.
- Produces quotient and remainder together.
- Uses a valid/ready handshake on input and output, plus a pipeline flush.

Parameters:
- XLEN, 64, operand/result width. Only 64 is supported.
- CNT_W, 7, iteration counter width; must hold XLEN.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- div_valid  in  1  request valid.
- div_ready  out  1  high only in IDLE; the request is accepted on div_valid && div_ready.
- dividend  in  64  dividend; sampled at accept.
- divisor  in  64  divisor; sampled at accept.
- div_signed  in  1  1 = signed operation (DIV/REM), 0 = unsigned.
- divw  in  1  1 = word operation: low 32 bits of each operand are used; 32 iterations.
- flush  in  1  abort; returns the block to IDLE.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result on out_valid && out_ready.
- quotient  out  64  quotient.
- remainder  out  64  remainder.

Behaviour:
- Reset (asynchronous, immediate): state = IDLE, div_ready = 1, out_valid = 0, quotient = 0, remainder = 0, counter = 0.
- State IDLE
  - On accept, latch operands, mode, and operand signs, then go to CALC with counter = N (N = 64, or 32 if divw).
  - Operand preparation:
    - Word operation: operands are the low 32 bits, sign-extended if div_signed, otherwise zero-extended.
    - Signed operation: take absolute values.
- State CALC, one iteration per cycle:
  - partial remainder (XLEN+1 bits) = {rem, next dividend bit}.
  - If partial remainder >= |divisor|: subtract it and shift in quotient bit 1; otherwise shift in 0.
  - Decrement the counter.
  - When the counter reaches 1, the next state is DONE.
- Result correction, registered on entry to DONE:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Word operation: both results are sign-extended from bit 31, for the unsigned word forms as well.
- Special cases (the iterations still run unless the optional feature is enabled):
  - Divisor == 0 (within the 32-bit view for word operations): quotient = all ones, remainder = dividend (word-extended).
  - Signed overflow (most-negative / -1, in either 64- or 32-bit view): quotient = dividend, remainder = 0.
- State DONE
  - out_valid = 1; quotient and remainder are held stable until out_ready.
  - On out_valid && out_ready, go to IDLE; div_ready rises the next cycle.
- Latency: accept at cycle T gives out_valid at T+N+1 (65 cycles for 64-bit, 33 for word). No new request is taken in the same cycle a result is consumed.
- Flush
  - Any state goes to IDLE on the next edge; out_valid drops and the result is discarded.
  - Flush has priority over div_valid in the same cycle (no accept) and over out_ready.
- Output registers retain their last value in IDLE and CALC; consumers qualify them with out_valid.

Optional Feature:
- Macro: YSYX_22040632_DIV_FASTPATH_EN.
- Defined:
  - A zero divisor or signed overflow detected at accept goes straight from IDLE to DONE.
  - The special-case result is presented at T+1.
  - Results are identical to the non-fastpath case.
- Undefined: no bypass; these cases take the full N+1 latency.

Test Plan:
1. Signed 64-bit: 100 / 7 -> quotient 14, remainder 2; out_valid exactly 65 cycles after accept.
2. Signed 64-bit: -7 / 2 -> quotient 0xFFFFFFFFFFFFFFFD, remainder 0xFFFFFFFFFFFFFFFF. Unsigned: 0xFFFFFFFFFFFFFFFF / 2 -> quotient 0x7FFFFFFFFFFFFFFF, remainder 1.
3. Division by zero: 5 / 0 -> quotient 0xFFFFFFFFFFFFFFFF, remainder 5. Latency 65 without the macro, 1 with it.
4. Overflow: 0x8000000000000000 / 0xFFFFFFFFFFFFFFFF, signed -> quotient 0x8000000000000000, remainder 0. Word: 0x80000000 / 0xFFFFFFFF signed -> quotient 0xFFFFFFFF80000000, remainder 0.
5. Word unsigned (DIVUW): 0x12345678FFFFFFFF / 1 -> quotient 0xFFFFFFFFFFFFFFFF, remainder 0; out_valid at T+33.
6. Handshake and flush:
   - out_ready held low 3 cycles -> out_valid and results stay stable, div_ready stays 0.
   - flush 10 cycles into CALC -> no out_valid; div_ready = 1 the next cycle.
   - A following 100 / 7 -> 14 rem 2.
   - Reset asserted mid-CALC -> outputs immediately 0 and div_ready = 1.
